fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
- Read-side client of the async FIFO. Runs in the read clock domain and drains the FIFO's first-word-fall-through read port (rdata/rempty/rinc).
- Packs PACK consecutive DSIZE-bit words into one wide beat and presents it on a valid/ready stream to downstream logic.
- A flush request, or the optional idle timeout, emits a partial beat with its word count.

Parameters:
- DSIZE, 8: width of one FIFO word; must match the FIFO's DSIZE.
- PACK, 4: words per output beat; legal range 2..16.
- TIMEOUT, 16: idle cycles before an automatic partial flush; used only with FIFO_RD_TIMEOUT_EN; legal range 1..255.

Ports:
- rclk  in  1  read-domain clock, the same clock as the FIFO's rclk.
- rrst  in  1  reset, asynchronous assert, active-high.
- rdata  in  DSIZE  FIFO head word; valid whenever rempty=0.
- rempty  in  1  FIFO empty flag.
- rinc  out  1  pop strobe to the FIFO; combinational.
- flush  in  1  request to emit the accumulated partial beat; level or pulse.
- out_data  out  PACK*DSIZE  packed beat; the first-popped word sits in bits [DSIZE-1:0].
- out_cnt  out  $clog2(PACK)+1  number of valid words in out_data, range 1..PACK.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset: already decided, one clock (rclk); reset rrst is asynchronous and active-high. While rrst=1, all of the following are 0: out_valid, out_data, out_cnt, the accumulator, the word count cnt, flush_pend and the idle counter. rinc=0 while rrst=1.
- Storage: accumulator acc of (PACK-1)*DSIZE bits, word count cnt (0..PACK-1), output register, flush_pend flag.
- slot_free = !out_valid || out_ready, meaning the output register can be loaded this cycle.
- Pop rule: rinc = !rrst && !rempty && !emit_partial && (cnt < PACK-1 || slot_free). Never pop while rempty=1.
- Pop with cnt < PACK-1: write rdata into acc word [cnt]; cnt increments.
- Pop with cnt = PACK-1: load the output register with {rdata, acc}; set out_cnt=PACK and out_valid=1; cnt returns to 0. Latency is one rclk from the completing pop to out_valid.
- Throughput: one full beat per PACK cycles with rempty=0 and out_ready=1. There is no bubble between beats.
- Handshake: a beat transfers on out_valid && out_ready. While out_valid=1 && out_ready=0, out_data and out_cnt hold stable. out_valid drops the cycle after a transfer unless a new beat loads in the same cycle.
- flush_pend is set by flush=1 when cnt > 0 or a pop is occurring. flush with cnt=0 and no pop is ignored.
- emit_partial = flush_pend && cnt > 0 && slot_free.
  - In that cycle: load the output register with acc, upper words zero; out_cnt=cnt; out_valid=1; cnt=0; flush_pend cleared; rinc forced 0.
  - A flush arriving in the same cycle as a completing pop is satisfied by that full beat; flush_pend then clears.
- State view, two states:
  - IDLE (cnt=0) goes to FILL on a pop.
  - FILL goes to IDLE on a completing pop or an emit_partial.
  - Output-register occupancy is tracked independently by out_valid.
- Backpressure boundary: with cnt=PACK-1 and the output register occupied (out_ready=0), rinc stays 0 and the FIFO word stays at its head. No data is lost or duplicated.
- rempty toggling mid-beat: the accumulator holds indefinitely; no timeout exists in the base build.
- Reset mid-beat: partially accumulated words and any held beat are discarded. The FIFO's own reset is the caller's responsibility.

Optional Feature:
- Macro FIFO_RD_TIMEOUT_EN.
- Defined: an 8-bit idle counter increments each cycle in which cnt > 0 and no pop occurs, and clears on any pop or emit. When it reaches TIMEOUT, flush_pend is set internally, identical to an external flush.
- Not defined: the counter is absent and partial beats are emitted only via flush.

Test Plan:
- Fill FIFO with 0x11,0x22,0x33,0x44, out_ready=1 → one beat, out_data=0x44332211, out_cnt=4, out_valid one cycle after the 4th pop.
- Stream 8 words 0x01..0x08 back-to-back, out_ready=1 → beats 0x04030201 then 0x08070605 on consecutive 4-cycle boundaries, with rinc=1 on all 8 cycles.
- Hold out_ready=0 after first beat, supply 8 words → rinc=0 once cnt=3 with second beat complete-pending; release out_ready → 0x04030201 then 0x08070605 in order, no loss.
- Push 0xAA,0xBB then pulse flush → out_data=0x0000BBAA, out_cnt=2; a flush pulse with cnt=0 produces no beat.
- Assert rrst for one cycle with cnt=2 and out_valid=1 → out_valid=0 and cnt=0 immediately (asynchronously); the next 4 words form a clean beat.
- With FIFO_RD_TIMEOUT_EN and TIMEOUT=16: push 0x5A, then keep FIFO empty → partial beat 0x0000005A, out_cnt=1, emitted 17 cycles after the pop.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side client of the async FIFO (read clock domain).
// Drains the first-word-fall-through port and packs PACK words of DSIZE bits
// into one beat on a valid/ready stream. The first-popped word lands in the
// low bits. A flush emits the partially filled beat together with its word
// count.
// Optional build macro FIFO_RD_TIMEOUT_EN adds an idle counter. After TIMEOUT
// idle cycles with words held, it raises the flush request internally.
module fifo_rd_packer #(
  parameter int DSIZE   = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic [DSIZE-1:0]        rdata,
  input  logic                    rempty,
  output logic                    rinc,
  input  logic                    flush,
  output logic [PACK*DSIZE-1:0]   out_data,
  output logic [$clog2(PACK):0]   out_cnt,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CW = $clog2(PACK);
  localparam int OW = $clog2(PACK) + 1;
  localparam int AW = (PACK - 1) * DSIZE;
  localparam logic [CW-1:0] CNT_LAST = CW'(PACK - 1);
  localparam logic [OW-1:0] CNT_FULL = OW'(PACK);

  // Parameter legality is checked when the design is elaborated.
  if (PACK < 2 || PACK > 16) begin : g_bad_pack
    $error("fifo_rd_packer: PACK must be in 2..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fifo_rd_packer: TIMEOUT must be in 1..255");
  end

  // IDLE means no words are held (cnt = 0). FILL means a partial beat is
  // accumulating. The output register is tracked separately by out_valid_r.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [AW-1:0]          acc_r, acc_s;
  logic [PACK*DSIZE-1:0]  out_data_r, out_data_s;
  logic [OW-1:0]          out_cnt_r, out_cnt_s;
  logic                   out_valid_r, out_valid_s;
  logic                   flush_pend_r, flush_pend_s;
  logic                   slot_free_s;
  logic                   emit_partial_s;
  logic                   pop_s;
  logic                   complete_s;
  logic                   flush_req_s;

  // Output-slot availability, partial-emit decision and pop qualification.
  always_comb begin
    slot_free_s    = !out_valid_r || out_ready;
    emit_partial_s = flush_pend_r && (state_r == ST_FILL) && slot_free_s;
    pop_s          = !rrst && !rempty && !emit_partial_s &&
                     ((cnt_r != CNT_LAST) || slot_free_s);
    complete_s     = pop_s && (cnt_r == CNT_LAST);
  end

  assign rinc      = pop_s;
  assign out_data  = out_data_r;
  assign out_cnt   = out_cnt_r;
  assign out_valid = out_valid_r;

`ifdef FIFO_RD_TIMEOUT_EN
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

  logic [7:0] idle_r, idle_s;
  logic       timeout_hit_s;

  // The idle counter advances while words are held and nothing moves. The
  // hit fires on the cycle in which the counter reaches TIMEOUT.
  always_comb begin
    idle_s        = idle_r;
    timeout_hit_s = 1'b0;
    if (pop_s || emit_partial_s) begin
      idle_s = 8'd0;
    end else if (state_r == ST_FILL) begin
      if (idle_r == IDLE_LAST) begin
        timeout_hit_s = 1'b1;
      end else begin
        timeout_hit_s = 1'b0;
      end
      if (idle_r != 8'hFF) begin
        idle_s = idle_r + 8'd1;
      end else begin
        idle_s = idle_r;
      end
    end else begin
      idle_s = 8'd0;
    end
  end

  // Idle counter register.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      idle_r <= 8'd0;
    end else begin
      idle_r <= idle_s;
    end
  end

  assign flush_req_s = flush || timeout_hit_s;
`else
  assign flush_req_s = flush;
`endif

  // Next-state logic for the fill FSM, accumulator, output register and flush.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    acc_s        = acc_r;
    out_data_s   = out_data_r;
    out_cnt_s    = out_cnt_r;
    out_valid_s  = out_valid_r;
    flush_pend_s = flush_pend_r;

    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_s = ST_FILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (complete_s || emit_partial_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FILL;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A transfer empties the slot unless a new beat loads in the same cycle.
    if (out_ready) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end

    if (complete_s) begin
      out_data_s  = {rdata, acc_r};
      out_cnt_s   = CNT_FULL;
      out_valid_s = 1'b1;
      cnt_s       = '0;
      acc_s       = '0;
    end else if (emit_partial_s) begin
      // Unused words are already zero because the accumulator is cleared on every emit.
      out_data_s  = {{DSIZE{1'b0}}, acc_r};
      out_cnt_s   = {1'b0, cnt_r};
      out_valid_s = 1'b1;
      cnt_s       = '0;
      acc_s       = '0;
    end else if (pop_s) begin
      for (int i = 0; i < PACK - 1; i++) begin
        if (cnt_r == CW'(i)) begin
          acc_s[i*DSIZE +: DSIZE] = rdata;
        end else begin
          acc_s[i*DSIZE +: DSIZE] = acc_r[i*DSIZE +: DSIZE];
        end
      end
      cnt_s = cnt_r + CW'(1);
    end else begin
      cnt_s = cnt_r;
    end

    // A full beat also satisfies a pending or simultaneous flush.
    if (complete_s || emit_partial_s) begin
      flush_pend_s = 1'b0;
    end else if (flush_req_s && ((state_r == ST_FILL) || pop_s)) begin
      flush_pend_s = 1'b1;
    end else begin
      flush_pend_s = flush_pend_r;
    end
  end

  // State and datapath registers. Reset discards held words and any pending beat.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      acc_r        <= '0;
      out_data_r   <= '0;
      out_cnt_r    <= '0;
      out_valid_r  <= 1'b0;
      flush_pend_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      acc_r        <= acc_s;
      out_data_r   <= out_data_s;
      out_cnt_r    <= out_cnt_s;
      out_valid_r  <= out_valid_s;
      flush_pend_r <= flush_pend_s;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer.
// Part 1 applies table vectors.
// Part 2 runs hand-written multi-cycle sequences.
// Part 3 applies random traffic.
// A queue-based reference model is checked every cycle.
module tb_fifo_rd_packer;
  localparam int DSIZE   = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 16;

  logic        rclk = 1'b0;
  logic        rrst;
  logic [7:0]  rdata;
  logic        rempty;
  logic        rinc;
  logic        flush;
  logic [31:0] out_data;
  logic [2:0]  out_cnt;
  logic        out_valid;
  logic        out_ready;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.DSIZE(DSIZE), .PACK(PACK), .TIMEOUT(TIMEOUT)) dut (
    .rclk(rclk), .rrst(rrst), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .flush(flush), .out_data(out_data), .out_cnt(out_cnt),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  fifo_q[$];
  logic [7:0]  m_acc[$];
  logic        m_valid;
  logic        m_pend;
  logic [31:0] m_data;
  int          m_cnt;
  int          m_idle;

  logic        s_rinc;
  logic        s_valid;
  logic [31:0] s_data;
  logic [2:0]  s_cnt;

  typedef struct {
    string       name;
    logic [31:0] words;
    int          nwords;
    logic        do_flush;
    logic        exp_beat;
    logic [31:0] exp_data;
    int          exp_cnt;
    int          exp_tick;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    m_acc.delete();
    m_valid = 1'b0;
    m_pend  = 1'b0;
    m_data  = 32'h0;
    m_cnt   = 0;
    m_idle  = 0;
  endtask

  // One clock cycle. The caller has already set flush and out_ready.
  task automatic tick();
    logic       sf, em, pp, done, hit;
    logic [7:0] w;
    logic [31:0] d;
    int         sz;
    rempty = (fifo_q.size() == 0);
    rdata  = rempty ? 8'h00 : fifo_q[0];
    #1;
    sz = m_acc.size();
    sf = !m_valid || out_ready;
    em = m_pend && (sz > 0) && sf;
    pp = !rempty && !em && ((sz < PACK - 1) || sf);
    chk("rinc", 32'(rinc), 32'(pp));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_data", out_data, m_data);
      chk("out_cnt", 32'(out_cnt), 32'(m_cnt));
    end
    s_rinc  = rinc;
    s_valid = out_valid;
    s_data  = out_data;
    s_cnt   = out_cnt;
    @(posedge rclk);
    done = 1'b0;
    hit  = 1'b0;
    if (m_valid && out_ready) m_valid = 1'b0;
    if (pp) begin
      w = fifo_q.pop_front();
      if (sz == PACK - 1) begin
        d = 32'h0;
        for (int i = 0; i < sz; i++) d[i*8 +: 8] = m_acc[i];
        d[31:24] = w;
        m_data  = d;
        m_cnt   = PACK;
        m_valid = 1'b1;
        m_acc.delete();
        done = 1'b1;
      end else begin
        m_acc.push_back(w);
      end
    end
    if (em) begin
      d = 32'h0;
      for (int i = 0; i < sz; i++) d[i*8 +: 8] = m_acc[i];
      m_data  = d;
      m_cnt   = sz;
      m_valid = 1'b1;
      m_acc.delete();
    end
`ifdef FIFO_RD_TIMEOUT_EN
    if (pp || em) begin
      m_idle = 0;
    end else if (sz > 0) begin
      if (m_idle < 255) m_idle++;
      hit = (m_idle == TIMEOUT);
    end else begin
      m_idle = 0;
    end
`endif
    if (done || em) m_pend = 1'b0;
    else if ((flush || hit) && (sz > 0 || pp)) m_pend = 1'b1;
    #1;
  endtask

  task automatic do_reset(input logic check);
    flush     = 1'b0;
    out_ready = 1'b0;
    fifo_q.delete();
    rempty = 1'b0;
    rdata  = 8'h77;
    rrst   = 1'b1;
    @(posedge rclk);
    #1;
    if (check) begin
      chk("reset_out_valid", 32'(out_valid), 32'h0);
      chk("reset_out_data", out_data, 32'h0);
      chk("reset_out_cnt", 32'(out_cnt), 32'h0);
      chk("reset_rinc", 32'(rinc), 32'h0);
    end
    rrst   = 1'b0;
    rempty = 1'b1;
    clear_model();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          nb, gt, nr, ft;
    logic [31:0] gd;
    int          gc;
    logic [31:0] beats[$];
    int          btick[$];
    longint      in_cnt, out_cnt_sum, in_sum, out_sum;
    int          pr, rr;
    logic [7:0]  b;

    rrst = 1'b1; flush = 1'b0; out_ready = 1'b0; rempty = 1'b1; rdata = 8'h00;
    clear_model();
    @(posedge rclk);
    #1;
    do_reset(1'b1);

    // Table-driven single-beat cases.
    vecs[0] = '{"full4",           32'h44332211, 4, 1'b0, 1'b1, 32'h44332211, 4, 4};
    vecs[1] = '{"flush2",          32'h0000BBAA, 2, 1'b1, 1'b1, 32'h0000BBAA, 2, 4};
    vecs[2] = '{"flush_empty",     32'h00000000, 0, 1'b1, 1'b0, 32'h00000000, 0, 0};
    vecs[3] = '{"flush3",          32'h000C0B0A, 3, 1'b1, 1'b1, 32'h000C0B0A, 3, 5};
    vecs[4] = '{"flush1",          32'h0000005A, 1, 1'b1, 1'b1, 32'h0000005A, 1, 3};
    vecs[5] = '{"full_then_flush", 32'hDEADBEEF, 4, 1'b1, 1'b1, 32'hDEADBEEF, 4, 4};

    for (int v = 0; v < 6; v++) begin
      do_reset(1'b0);
      out_ready = 1'b1;
      for (int i = 0; i < vecs[v].nwords; i++) fifo_q.push_back(vecs[v].words[i*8 +: 8]);
      nb = 0; gd = 32'h0; gc = 0; gt = -1;
      for (int t = 0; t < 12; t++) begin
        flush = vecs[v].do_flush && (t == vecs[v].nwords);
        tick();
        if (s_valid) begin
          if (nb == 0) begin gd = s_data; gc = 32'(s_cnt); gt = t; end
          nb++;
        end
      end
      flush = 1'b0;
      chk({vecs[v].name, "_beats"}, 32'(nb), vecs[v].exp_beat ? 32'd1 : 32'd0);
      if (vecs[v].exp_beat) begin
        chk({vecs[v].name, "_data"}, gd, vecs[v].exp_data);
        chk({vecs[v].name, "_cnt"}, 32'(gc), 32'(vecs[v].exp_cnt));
        chk({vecs[v].name, "_tick"}, 32'(gt), 32'(vecs[v].exp_tick));
      end
    end

    // Back-to-back stream: 8 pops in a row and beats four cycles apart.
    do_reset(1'b0);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    nr = 0; beats.delete(); btick.delete();
    for (int t = 0; t < 12; t++) begin
      tick();
      if (t < 8 && s_rinc) nr++;
      if (s_valid) begin beats.push_back(s_data); btick.push_back(t); end
    end
    chk("stream_rinc_run", 32'(nr), 32'd8);
    chk("stream_beats", 32'(beats.size()), 32'd2);
    if (beats.size() == 2) begin
      chk("stream_beat0", beats[0], 32'h04030201);
      chk("stream_beat1", beats[1], 32'h08070605);
      chk("stream_tick0", 32'(btick[0]), 32'd4);
      chk("stream_tick1", 32'(btick[1]), 32'd8);
    end

    // Backpressure: the completing pop stalls until the slot drains.
    do_reset(1'b0);
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) fifo_q.push_back(8'(i));
    for (int t = 0; t < 14; t++) tick();
    chk("bp_rinc_stall", 32'(s_rinc), 32'h0);
    chk("bp_hold_valid", 32'(out_valid), 32'h1);
    chk("bp_hold_data", out_data, 32'h04030201);
    chk("bp_fifo_left", 32'(fifo_q.size()), 32'd1);
    out_ready = 1'b1;
    beats.delete();
    for (int t = 0; t < 10; t++) begin
      tick();
      if (s_valid) beats.push_back(s_data);
    end
    chk("bp_beats", 32'(beats.size()), 32'd2);
    if (beats.size() == 2) begin
      chk("bp_beat0", beats[0], 32'h04030201);
      chk("bp_beat1", beats[1], 32'h08070605);
    end

    // Asynchronous reset with a held beat and two accumulated words.
    do_reset(1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'hB1 + 8'(i));
    for (int t = 0; t < 10; t++) tick();
    fifo_q.push_back(8'h99);
    rempty = 1'b0;
    rdata  = 8'h99;
    #1;
    chk("rst_pre_rinc", 32'(rinc), 32'h1);
    chk("rst_pre_valid", 32'(out_valid), 32'h1);
    rrst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(out_valid), 32'h0);
    chk("rst_async_cnt", 32'(out_cnt), 32'h0);
    chk("rst_async_data", out_data, 32'h0);
    chk("rst_async_rinc", 32'(rinc), 32'h0);
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    fifo_q.delete();
    clear_model();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'hA1 + 8'(i));
    nb = 0; gd = 32'h0; gc = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (s_valid) begin gd = s_data; gc = 32'(s_cnt); nb++; end
    end
    chk("rst_after_beats", 32'(nb), 32'd1);
    chk("rst_after_data", gd, 32'hA4A3A2A1);
    chk("rst_after_cnt", 32'(gc), 32'd4);

`ifdef FIFO_RD_TIMEOUT_EN
    // One word and then silence. The emit cycle is 17 cycles after the pop cycle.
    do_reset(1'b0);
    out_ready = 1'b1;
    fifo_q.push_back(8'h5A);
    ft = -1; gd = 32'h0; gc = 0;
    for (int t = 0; t < 25; t++) begin
      tick();
      if (s_valid && ft < 0) begin ft = t; gd = s_data; gc = 32'(s_cnt); end
    end
    chk("timeout_tick", 32'(ft), 32'd18);
    chk("timeout_data", gd, 32'h0000005A);
    chk("timeout_cnt", 32'(gc), 32'd1);
`endif

    // Random traffic with the per-cycle model, plus a word-conservation check.
    do_reset(1'b0);
    in_cnt = 0; out_cnt_sum = 0; in_sum = 0; out_sum = 0;
    for (int c = 0; c < 3000; c++) begin
      case ((c / 500) % 3)
        0:       begin pr = 70; rr = 90; end
        1:       begin pr = 30; rr = 50; end
        default: begin pr = 95; rr = 20; end
      endcase
      if (fifo_q.size() < 12 && $urandom_range(0, 99) < pr) begin
        b = 8'($urandom_range(0, 255));
        fifo_q.push_back(b);
        in_cnt++;
        in_sum += b;
      end
      flush     = ($urandom_range(0, 99) < 4);
      out_ready = ($urandom_range(0, 99) < rr);
      tick();
      if (s_valid && out_ready) begin
        out_cnt_sum += s_cnt;
        for (int i = 0; i < 4; i++) if (i < s_cnt) out_sum += s_data[i*8 +: 8];
      end
    end
    for (int c = 0; c < 40; c++) begin
      flush     = 1'b1;
      out_ready = 1'b1;
      tick();
      if (s_valid && out_ready) begin
        out_cnt_sum += s_cnt;
        for (int i = 0; i < 4; i++) if (i < s_cnt) out_sum += s_data[i*8 +: 8];
      end
    end
    flush = 1'b0;
    chk("rand_fifo_drained", 32'(fifo_q.size()), 32'd0);
    chk("rand_word_count", 32'(out_cnt_sum), 32'(in_cnt));
    chk("rand_word_sum", 32'(out_sum), 32'(in_sum));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
